// File: rtl/sprite_char_ctrl.sv
// rtl/sprite_char_ctrl.sv - player character controller: command latch, movement, animation and sprite streaming
module sprite_char_ctrl #(
    parameter int          SPRITE_W    = 16,
    parameter int          SPRITE_H    = 16,
    parameter int          STEP        = 1,
    parameter int          X_MIN       = 0,
    parameter int          X_MAX       = 304,
    parameter int          Y_MIN       = 0,
    parameter int          Y_MAX       = 224,
    parameter int          X_INIT      = 1,
    parameter int          Y_INIT      = 96,
    parameter int          ANIM_DIV    = 8,
    parameter int          ATTACK_LEN  = 16,
    parameter int          MEM_LAT     = 1,
    parameter logic [5:0]  TRANSPARENT = 6'h3F,
    localparam int         ADDR_W      = $clog2(16 * SPRITE_W * SPRITE_H)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              c_attack,
    input  logic              c_up,
    input  logic              c_down,
    input  logic              c_left,
    input  logic              c_right,
    input  logic              init,
    input  logic              reg_action,
    input  logic              apply_action,
    input  logic              draw_start,
    input  logic [1:0]        collision,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [5:0]        mem_data,
    output logic [8:0]        x_pos,
    output logic [7:0]        y_pos,
    output logic [2:0]        direction,
    output logic [2:0]        facing,
    output logic              attacking,
    output logic              busy,
    output logic [8:0]        x_draw,
    output logic [7:0]        y_draw,
    output logic [5:0]        colour,
    output logic              VGA_write,
    output logic              draw_done
);

    localparam int COL_W  = $clog2(SPRITE_W);
    localparam int ROW_W  = $clog2(SPRITE_H);
    localparam int CNT_W  = COL_W + ROW_W;
    localparam int WALK_W = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
    localparam int ATK_W  = $clog2(ATTACK_LEN + 1);

    localparam logic [2:0] D_NONE   = 3'd0;
    localparam logic [2:0] D_ATTACK = 3'd1;
    localparam logic [2:0] D_UP     = 3'd2;
    localparam logic [2:0] D_DOWN   = 3'd3;
    localparam logic [2:0] D_LEFT   = 3'd4;
    localparam logic [2:0] D_RIGHT  = 3'd5;

    localparam logic [CNT_W-1:0] LAST_PIX = CNT_W'(SPRITE_W * SPRITE_H - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DRAW,
        S_FLUSH
    } draw_state_e;

    // character state
    logic [8:0]        x_pos_q, x_pos_d;
    logic [7:0]        y_pos_q, y_pos_d;
    logic [2:0]        dir_q, dir_d;
    logic [2:0]        facing_q, facing_d;
    logic              attacking_q, attacking_d;
    logic [ATK_W-1:0]  atk_cnt_q, atk_cnt_d;
    logic              frame_q, frame_d;
    logic [WALK_W-1:0] walk_q, walk_d;

    // draw engine state
    draw_state_e       state_q, state_d;
    logic [CNT_W-1:0]  pix_q, pix_d;
    logic [1:0]        flush_q, flush_d;
    logic [8:0]        snap_x_q, snap_x_d;
    logic [7:0]        snap_y_q, snap_y_d;
    logic [3:0]        snap_slot_q, snap_slot_d;
    logic              done_q, done_d;

    // address-to-data alignment pipeline
    logic [MEM_LAT-1:0] vld_q;
    logic [8:0]         xp_q [MEM_LAT];
    logic [7:0]         yp_q [MEM_LAT];

    logic [1:0]       facing_idx;
    logic [3:0]       slot;
    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;
    logic             unused_collision;

    assign unused_collision = collision[1];

    always_comb begin
        case (facing_q)
            D_LEFT:  facing_idx = 2'd1;
            D_UP:    facing_idx = 2'd2;
            D_RIGHT: facing_idx = 2'd3;
            default: facing_idx = 2'd0;
        endcase
    end

    assign slot = {attacking_q, facing_idx, frame_q & ~attacking_q};
    assign col  = pix_q[COL_W-1:0];
    assign row  = pix_q[CNT_W-1:COL_W];

    always_comb begin
        x_pos_d     = x_pos_q;
        y_pos_d     = y_pos_q;
        dir_d       = dir_q;
        facing_d    = facing_q;
        attacking_d = attacking_q;
        atk_cnt_d   = atk_cnt_q;
        frame_d     = frame_q;
        walk_d      = walk_q;
        if (reg_action) begin
            if (attacking_q)    dir_d = D_NONE;
            else if (c_attack)  dir_d = D_ATTACK;
            else if (c_up)      dir_d = D_UP;
            else if (c_down)    dir_d = D_DOWN;
            else if (c_left)    dir_d = D_LEFT;
            else if (c_right)   dir_d = D_RIGHT;
            else                dir_d = D_NONE;
        end else if (apply_action) begin
            if (attacking_q) begin
                atk_cnt_d = atk_cnt_q - 1'b1;
                if (atk_cnt_q == ATK_W'(1)) attacking_d = 1'b0;
            end else if (dir_q == D_ATTACK) begin
                atk_cnt_d   = ATK_W'(ATTACK_LEN);
                attacking_d = 1'b1;
            end else if (dir_q >= D_UP && dir_q <= D_RIGHT) begin
                facing_d = dir_q;
                // saturate at the playfield edges instead of wrapping
                if (!collision[0]) begin
                    case (dir_q)
                        D_UP:
                            if (int'(y_pos_q) - STEP <= Y_MIN) y_pos_d = 8'(Y_MIN);
                            else                               y_pos_d = y_pos_q - 8'(STEP);
                        D_DOWN:
                            if (int'(y_pos_q) + STEP >= Y_MAX) y_pos_d = 8'(Y_MAX);
                            else                               y_pos_d = y_pos_q + 8'(STEP);
                        D_LEFT:
                            if (int'(x_pos_q) - STEP <= X_MIN) x_pos_d = 9'(X_MIN);
                            else                               x_pos_d = x_pos_q - 9'(STEP);
                        default:
                            if (int'(x_pos_q) + STEP >= X_MAX) x_pos_d = 9'(X_MAX);
                            else                               x_pos_d = x_pos_q + 9'(STEP);
                    endcase
                end
                if (walk_q == WALK_W'(ANIM_DIV - 1)) begin
                    walk_d  = '0;
                    frame_d = ~frame_q;
                end else begin
                    walk_d = walk_q + 1'b1;
                end
            end else begin
                frame_d = 1'b0;
                walk_d  = '0;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        pix_d       = pix_q;
        flush_d     = flush_q;
        snap_x_d    = snap_x_q;
        snap_y_d    = snap_y_q;
        snap_slot_d = snap_slot_q;
        done_d      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (draw_start) begin
                    state_d     = S_DRAW;
                    pix_d       = '0;
                    snap_x_d    = x_pos_q;
                    snap_y_d    = y_pos_q;
                    snap_slot_d = slot;
                end
            end
            S_DRAW: begin
                if (pix_q == LAST_PIX) begin
                    state_d = S_FLUSH;
                    flush_d = '0;
                end else begin
                    pix_d = pix_q + 1'b1;
                end
            end
            S_FLUSH: begin
                // wait for the last read to come back before signalling completion
                if (flush_q == 2'(MEM_LAT - 1)) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end else begin
                    flush_d = flush_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset || init) begin
            x_pos_q     <= 9'(X_INIT);
            y_pos_q     <= 8'(Y_INIT);
            dir_q       <= D_NONE;
            facing_q    <= D_DOWN;
            attacking_q <= 1'b0;
            atk_cnt_q   <= '0;
            frame_q     <= 1'b0;
            walk_q      <= '0;
            state_q     <= S_IDLE;
            pix_q       <= '0;
            flush_q     <= '0;
            snap_x_q    <= '0;
            snap_y_q    <= '0;
            snap_slot_q <= '0;
            done_q      <= 1'b0;
            vld_q       <= '0;
            for (int i = 0; i < MEM_LAT; i++) begin
                xp_q[i] <= '0;
                yp_q[i] <= '0;
            end
        end else begin
            x_pos_q     <= x_pos_d;
            y_pos_q     <= y_pos_d;
            dir_q       <= dir_d;
            facing_q    <= facing_d;
            attacking_q <= attacking_d;
            atk_cnt_q   <= atk_cnt_d;
            frame_q     <= frame_d;
            walk_q      <= walk_d;
            state_q     <= state_d;
            pix_q       <= pix_d;
            flush_q     <= flush_d;
            snap_x_q    <= snap_x_d;
            snap_y_q    <= snap_y_d;
            snap_slot_q <= snap_slot_d;
            done_q      <= done_d;
            vld_q[0]    <= (state_q == S_DRAW);
            xp_q[0]     <= snap_x_q + 9'(col);
            yp_q[0]     <= snap_y_q + 8'(row);
            for (int i = 1; i < MEM_LAT; i++) begin
                vld_q[i] <= vld_q[i-1];
                xp_q[i]  <= xp_q[i-1];
                yp_q[i]  <= yp_q[i-1];
            end
        end
    end

    assign mem_addr  = (state_q == S_DRAW) ? {row, snap_slot_q, col} : '0;
    assign x_pos     = x_pos_q;
    assign y_pos     = y_pos_q;
    assign direction = dir_q;
    assign facing    = facing_q;
    assign attacking = attacking_q;
    assign busy      = (state_q != S_IDLE);
    assign x_draw    = xp_q[MEM_LAT-1];
    assign y_draw    = yp_q[MEM_LAT-1];
    assign colour    = mem_data;
    assign VGA_write = vld_q[MEM_LAT-1] && (mem_data != TRANSPARENT);
    assign draw_done = done_q;

endmodule

// File: tb/tb_sprite_char_ctrl.sv
// tb/tb_sprite_char_ctrl.sv - directed self-checking bench for sprite_char_ctrl at MEM_LAT 1 and 2
module tb_sprite_char_ctrl;

    logic clock = 1'b0;
    logic reset, c_attack, c_up, c_down, c_left, c_right;
    logic init, reg_action, apply_action, draw_start;
    logic [1:0] collision;

    logic [11:0] mem_addr1, mem_addr2;
    logic [5:0]  mem_data1, mem_data2;
    logic [8:0]  x_pos1, x_pos2, x_draw1, x_draw2;
    logic [7:0]  y_pos1, y_pos2, y_draw1, y_draw2;
    logic [2:0]  direction1, direction2, facing1, facing2;
    logic        attacking1, attacking2, busy1, busy2;
    logic [5:0]  colour1, colour2;
    logic        vga1, vga2, done1, done2;

    int n_cmp = 0;
    int n_mis = 0;

    localparam logic [4:0] CMD_NONE = 5'b00000;
    localparam logic [4:0] CMD_R    = 5'b00001;
    localparam logic [4:0] CMD_L    = 5'b00010;
    localparam logic [4:0] CMD_D    = 5'b00100;
    localparam logic [4:0] CMD_U    = 5'b01000;
    localparam logic [4:0] CMD_A    = 5'b10000;

    always #5 clock = ~clock;

    sprite_char_ctrl #(.MEM_LAT(1)) u_dut1 (
        .clock(clock), .reset(reset), .c_attack(c_attack), .c_up(c_up), .c_down(c_down),
        .c_left(c_left), .c_right(c_right), .init(init), .reg_action(reg_action),
        .apply_action(apply_action), .draw_start(draw_start), .collision(collision),
        .mem_addr(mem_addr1), .mem_data(mem_data1), .x_pos(x_pos1), .y_pos(y_pos1),
        .direction(direction1), .facing(facing1), .attacking(attacking1), .busy(busy1),
        .x_draw(x_draw1), .y_draw(y_draw1), .colour(colour1), .VGA_write(vga1),
        .draw_done(done1)
    );

    sprite_char_ctrl #(.MEM_LAT(2)) u_dut2 (
        .clock(clock), .reset(reset), .c_attack(c_attack), .c_up(c_up), .c_down(c_down),
        .c_left(c_left), .c_right(c_right), .init(init), .reg_action(reg_action),
        .apply_action(apply_action), .draw_start(draw_start), .collision(collision),
        .mem_addr(mem_addr2), .mem_data(mem_data2), .x_pos(x_pos2), .y_pos(y_pos2),
        .direction(direction2), .facing(facing2), .attacking(attacking2), .busy(busy2),
        .x_draw(x_draw2), .y_draw(y_draw2), .colour(colour2), .VGA_write(vga2),
        .draw_done(done2)
    );

    // sprite RAM: pixel 0 of every slot is transparent, everything else reads back address bits
    function automatic logic [5:0] ram_f(input logic [11:0] a);
        if (a[11:8] == 4'd0 && a[3:0] == 4'd0) return 6'h3F;
        return a[5:0];
    endfunction

    logic [5:0] rd1_q, rd2a_q, rd2b_q;
    always @(posedge clock) begin
        rd1_q  <= ram_f(mem_addr1);
        rd2a_q <= ram_f(mem_addr2);
        rd2b_q <= rd2a_q;
    end
    assign mem_data1 = rd1_q;
    assign mem_data2 = rd2b_q;

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic reg_cmd(input logic [4:0] cmd);
        {c_attack, c_up, c_down, c_left, c_right} = cmd;
        reg_action = 1'b1;
        step();
        reg_action = 1'b0;
        {c_attack, c_up, c_down, c_left, c_right} = CMD_NONE;
    endtask

    task automatic apply();
        apply_action = 1'b1;
        step();
        apply_action = 1'b0;
    endtask

    task automatic move(input logic [4:0] cmd);
        reg_cmd(cmd);
        apply();
    endtask

    function automatic int pix_bad(input int lat, input int cyc, input int slot, input int sx,
                                   input int sy, input logic w, input logic [8:0] xd,
                                   input logic [7:0] yd, input logic [5:0] col);
        int p;
        logic [11:0] a;
        logic [5:0] d;
        logic ew;
        p = cyc - 1 - lat;
        if (p < 0 || p > 255) return (w !== 1'b0) ? 1 : 0;
        a  = 12'((p / 16) * 256 + slot * 16 + (p % 16));
        d  = ram_f(a);
        ew = (d != 6'h3F);
        if (w !== ew) return 1;
        if (ew && (int'(xd) != sx + p % 16 || int'(yd) != sy + p / 16 || col != d)) return 1;
        return 0;
    endfunction

    // start a draw and watch both latencies cycle by cycle for 300 cycles
    task automatic run_draw(input int slot, input int sx, input int sy);
        int wr1, wr2, err1, err2, aerr, nd1, nd2, dc1, dc2, b1, b2, fx, fy;
        wr1 = 0; wr2 = 0; err1 = 0; err2 = 0; aerr = 0;
        nd1 = 0; nd2 = 0; dc1 = -1; dc2 = -1; b1 = 0; b2 = 0; fx = -1; fy = -1;
        draw_start = 1'b1;
        step();
        draw_start = 1'b0;
        for (int cyc = 1; cyc <= 300; cyc++) begin
            if (cyc <= 256) begin
                if (int'(mem_addr1) != ((cyc - 1) / 16) * 256 + slot * 16 + (cyc - 1) % 16) aerr++;
                if (mem_addr2 !== mem_addr1) aerr++;
            end
            err1 += pix_bad(1, cyc, slot, sx, sy, vga1, x_draw1, y_draw1, colour1);
            err2 += pix_bad(2, cyc, slot, sx, sy, vga2, x_draw2, y_draw2, colour2);
            if (vga1 === 1'b1) begin
                if (wr1 == 0) begin fx = int'(x_draw1); fy = int'(y_draw1); end
                wr1++;
            end
            if (vga2 === 1'b1) wr2++;
            if (done1 === 1'b1) begin nd1++; dc1 = cyc; end
            if (done2 === 1'b1) begin nd2++; dc2 = cyc; end
            if (busy1 === 1'b1) b1++;
            if (busy2 === 1'b1) b2++;
            step();
        end
        check_eq("draw_addr_seq", aerr, 0);
        check_eq("draw_pix1_err", err1, 0);
        check_eq("draw_pix2_err", err2, 0);
        check_eq("draw_writes1", wr1, 255);
        check_eq("draw_writes2", wr2, 255);
        check_eq("draw_first_x", fx, sx + 1);
        check_eq("draw_first_y", fy, sy);
        check_eq("draw_done1_cnt", nd1, 1);
        check_eq("draw_done2_cnt", nd2, 1);
        check_eq("draw_done1_cyc", dc1, 258);
        check_eq("draw_done2_cyc", dc2, 259);
        check_eq("draw_busy1_cyc", b1, 257);
        check_eq("draw_busy2_cyc", b2, 258);
    endtask

    task automatic draw_first_addr(input string tag, input int exp_addr);
        draw_start = 1'b1;
        step();
        draw_start = 1'b0;
        check_eq(tag, int'(mem_addr1), exp_addr);
        repeat (270) step();
        check_eq({tag, "_idle"}, int'(busy1 | busy2), 0);
    endtask

    initial begin
        int nd, nw;
        reset = 1'b0; init = 1'b0; reg_action = 1'b0; apply_action = 1'b0;
        draw_start = 1'b0; collision = 2'b00;
        {c_attack, c_up, c_down, c_left, c_right} = CMD_NONE;
        step();
        step();
        reset = 1'b1;
        step();
        check_eq("rst_x", int'(x_pos1), 1);
        check_eq("rst_y", int'(y_pos1), 96);
        check_eq("rst_facing", int'(facing1), 3);
        check_eq("rst_dir", int'(direction1), 0);
        check_eq("rst_busy", int'(busy1), 0);
        check_eq("rst_vga", int'(vga1), 0);
        check_eq("rst_done", int'(done1), 0);
        check_eq("rst_attacking", int'(attacking1), 0);
        check_eq("rst_x2", int'(x_pos2), 1);

        reg_cmd(CMD_R);
        check_eq("dir_right", int'(direction1), 5);
        apply();
        move(CMD_R);
        move(CMD_R);
        check_eq("right3_x", int'(x_pos1), 4);
        check_eq("right3_facing", int'(facing1), 5);
        collision = 2'b01;
        repeat (3) move(CMD_R);
        check_eq("blocked_x", int'(x_pos1), 4);
        check_eq("blocked_facing", int'(facing1), 5);
        collision = 2'b00;

        repeat (3) move(CMD_L);
        check_eq("left3_x", int'(x_pos1), 1);
        check_eq("left3_facing", int'(facing1), 4);
        move(CMD_L);
        check_eq("left_sat1", int'(x_pos1), 0);
        move(CMD_L);
        check_eq("left_sat2", int'(x_pos1), 0);

        repeat (130) move(CMD_D);
        check_eq("down_sat_y", int'(y_pos1), 224);
        check_eq("down_facing", int'(facing1), 3);

        reg_cmd(CMD_NONE);
        check_eq("dir_none", int'(direction1), 0);
        apply();

        // 8 blocked right moves: no motion, walk frame toggles to 1 -> slot 7
        collision = 2'b01;
        repeat (8) move(CMD_R);
        collision = 2'b00;
        check_eq("frame_x", int'(x_pos1), 0);
        check_eq("frame_facing", int'(facing1), 5);
        draw_first_addr("frame1_addr", 12'h070);

        move(CMD_NONE);
        run_draw(6, 0, 224);

        move(CMD_L);
        reg_cmd(CMD_A | CMD_U);
        check_eq("dir_attack", int'(direction1), 1);
        apply();
        check_eq("atk_on", int'(attacking1), 1);
        check_eq("atk_x", int'(x_pos1), 0);
        check_eq("atk_y", int'(y_pos1), 224);
        check_eq("atk_facing", int'(facing1), 4);
        reg_cmd(CMD_R);
        check_eq("atk_reg_none", int'(direction1), 0);
        draw_first_addr("atk_slot_addr", 12'h0A0);
        repeat (15) apply();
        check_eq("atk_still_on", int'(attacking1), 1);
        apply();
        check_eq("atk_off", int'(attacking1), 0);

        draw_start = 1'b1;
        step();
        draw_start = 1'b0;
        repeat (99) step();
        init = 1'b1;
        step();
        init = 1'b0;
        check_eq("abort_busy1", int'(busy1), 0);
        check_eq("abort_busy2", int'(busy2), 0);
        check_eq("abort_vga1", int'(vga1), 0);
        check_eq("abort_vga2", int'(vga2), 0);
        check_eq("abort_x", int'(x_pos1), 1);
        check_eq("abort_y", int'(y_pos1), 96);
        check_eq("abort_facing", int'(facing1), 3);
        nd = 0; nw = 0;
        for (int i = 0; i < 300; i++) begin
            if (done1 === 1'b1 || done2 === 1'b1) nd++;
            if (vga1 === 1'b1 || vga2 === 1'b1) nw++;
            step();
        end
        check_eq("abort_no_done", nd, 0);
        check_eq("abort_no_write", nw, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/sprite_char_ctrl.md
Name: sprite_char_ctrl

Overview:
Parametrised player-character controller. Latches user commands, moves the character with collision gating and boundary saturation, and sequences walk-frame and attack animation. Streams the current sprite from an external synchronous sprite RAM to the VGA writer, with memory-latency-aligned pixel outputs. It sits between the control FSM, the collision_detector and the VGA framebuffer writer, and is instanced per on-screen character.

Parameters:
SPRITE_W, 16, sprite width in pixels (power of 2)
SPRITE_H, 16, sprite height in pixels (power of 2)
STEP, 1, pixels moved per apply_action
X_MIN / X_MAX, 0 / 304, legal range of top-left x
Y_MIN / Y_MAX, 0 / 224, legal range of top-left y
X_INIT / Y_INIT, 1 / 96, spawn position
ANIM_DIV, 8, moves per walk-frame toggle (>=1)
ATTACK_LEN, 16, apply_action strobes an attack lasts (>=1)
MEM_LAT, 1, sprite RAM read latency in cycles (1 or 2)
TRANSPARENT, 6'h3F, colour code that is never written
(localparam ADDR_W = log2(16*SPRITE_W*SPRITE_H))

Ports:
clock in 1 system clock
reset in 1 synchronous, active-low reset (0 = reset)
c_attack, c_up, c_down, c_left, c_right in 1 each; user commands
init in 1 respawn strobe
reg_action in 1 latch-command strobe
apply_action in 1 execute-command strobe
draw_start in 1 begin-sprite-draw strobe
collision in 2 bit0 = blocked in current direction
mem_addr out ADDR_W sprite RAM address
mem_data in 6 sprite RAM read data
x_pos out 9; y_pos out 8; character top-left position
direction out 3 latched action (NO_ACTION=0, ATTACK=1, UP=2, DOWN=3, LEFT=4, RIGHT=5)
facing out 3 last movement direction, same codes
attacking out 1 attack animation active
busy out 1 draw in progress
x_draw out 9; y_draw out 8; colour out 6; VGA_write out 1; pixel stream to VGA
draw_done out 1 one-cycle end-of-draw pulse

Behaviour:
- Reset (reset==0 at a clock edge): x_pos=X_INIT, y_pos=Y_INIT, facing=DOWN, direction=NO_ACTION, attacking=0, walk frame=0, walk count=0, busy=0, VGA_write=0, draw_done=0, x_draw=0, y_draw=0, mem_addr=0. init does the same, minus the reset dependency.
- Strobe priority: reset > init > reg_action > apply_action. draw_start is evaluated in parallel with reg_action/apply_action.
- reg_action: direction <= first asserted of attack, up, down, left, right; NO_ACTION if none. While attacking=1, latch NO_ACTION.
- apply_action:
  - If attacking: attack counter decrements; attacking clears when it reaches 0.
  - Else if direction==ATTACK: counter <= ATTACK_LEN and attacking=1. Position and facing are unchanged.
  - Else if direction is a move: facing <= direction. If !collision[0], position moves by STEP, saturating at X_MIN/X_MAX/Y_MIN/Y_MAX (no wrap). Walk count increments; at ANIM_DIV-1 it wraps to 0 and the frame toggles. A blocked move still advances the animation.
  - Else (NO_ACTION): frame=0, walk count=0.
- Sprite slot = {attacking, facing_idx[1:0], frame}, with facing_idx DOWN=0, LEFT=1, UP=2, RIGHT=3. Frame is forced to 0 while attacking.
- mem_addr = {row, slot, col}, where row = pixel count high bits and col = pixel count low bits.
- Draw FSM states: IDLE, DRAW, FLUSH.
  - IDLE: draw_start -> DRAW, pixel count=0. Snapshot x_pos, y_pos and slot on entry; later position changes do not affect the in-flight draw.
  - DRAW: one address per cycle, column-fastest, SPRITE_W*SPRITE_H addresses. After the last address -> FLUSH.
  - FLUSH: lasts MEM_LAT cycles, then draw_done pulses for 1 cycle and the FSM returns to IDLE.
  - busy=1 in DRAW and FLUSH. draw_start while busy is ignored.
- Pixel alignment: x_draw/y_draw/valid are delayed MEM_LAT cycles to match mem_data.
  - colour = mem_data.
  - VGA_write = delayed valid && mem_data != TRANSPARENT.
  - x_draw = snap_x + col; y_draw = snap_y + row.
- Latency (draw_start sampled at edge N):
  - First address is driven in cycle N+1.
  - First pixel is valid in cycle N+1+MEM_LAT.
  - Last pixel is valid in cycle N+MEM_LAT+W*H.
  - draw_done pulses in cycle N+MEM_LAT+W*H+1.
- Reset or init mid-draw: abort. busy=0, VGA_write=0 from the next cycle, no draw_done.

Test Plan:
- Reset low for 2 cycles, then release -> x_pos=1, y_pos=96, facing=3, direction=0, busy=0, VGA_write=0.
- c_right held, 3x (reg_action, apply_action), collision=0 -> x_pos=4, facing=5. Repeat with collision[0]=1 -> x_pos stays 4, facing=5.
- Position 1, c_left moves -> x_pos saturates at 0. y_pos=224 with c_down -> stays 224.
- draw_start with a RAM model holding 6'h3F at pixel 0 and data=address elsewhere (MEM_LAT=1) -> 256 address cycles; 255 VGA_write pulses; first write at (x_pos+1, y_pos); draw_done exactly at N+258. Repeat with MEM_LAT=2 -> draw_done at N+259.
- c_attack then apply_action -> attacking=1 for 16 apply strobes; reg_action during that window latches 0; draw uses slot 8+facing_idx*2.
- init asserted 100 cycles into a draw -> busy=0 and no VGA_write next cycle, draw_done never pulses, position back to (1,96).
